// File: rtl/apagador_escalera_temporizado.sv
// apagador_escalera_temporizado
// Clocked two-way staircase light: two raw lever inputs are synchronised and
// debounced, and any accepted flip of either lever toggles the lamp.
// Optional auto-off timer enabled by defining APAGADOR_AUTO_OFF_EN.
module apagador_escalera_temporizado #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic abajo,
    input  logic arriba,
    output logic foco,
    output logic evento
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values the debouncer and timer cannot represent.
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("apagador_escalera_temporizado: DEBOUNCE_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic {
        APAGADO   = 1'b0,
        ENCENDIDO = 1'b1
    } estado_t;

    // Bit 0 is the downstairs lever, bit 1 the upstairs lever.
    logic [1:0]    crudo;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    nivel;
    logic [1:0]    cambio;
    logic [CW-1:0] cnt [2];
    logic          t;

    estado_t estado;
    estado_t estado_sig;
    logic    evento_sig;

`ifdef APAGADOR_AUTO_OFF_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_sig;
`endif

    assign crudo = {arriba, abajo};

    // Two-flop synchroniser; reset preloads the raw levels so held levers do not toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= crudo;
            s2 <= crudo;
        end else begin
            s1 <= crudo;
            s2 <= s1;
        end
    end

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            nivel  <= crudo;
            cambio <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                cambio[i] <= 1'b0;
                if (s2[i] != nivel[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        nivel[i]  <= s2[i];
                        cnt[i]    <= '0;
                        cambio[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Simultaneous flips of both levers cancel each other.
    assign t = cambio[0] ^ cambio[1];

    // FSM state register; evento is registered so it lines up with the foco change.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= APAGADO;
            evento <= 1'b0;
`ifdef APAGADOR_AUTO_OFF_EN
            timer  <= '0;
`endif
        end else begin
            estado <= estado_sig;
            evento <= evento_sig;
`ifdef APAGADOR_AUTO_OFF_EN
            timer  <= timer_sig;
`endif
        end
    end

    // Next-state logic: toggles flip the lamp, timeout (if enabled) forces it off.
    always_comb begin
        estado_sig = estado;
        evento_sig = t;
`ifdef APAGADOR_AUTO_OFF_EN
        timer_sig  = '0;
`endif
        case (estado)
            APAGADO: begin
                if (t) begin
                    estado_sig = ENCENDIDO;
                end
            end
            ENCENDIDO: begin
`ifdef APAGADOR_AUTO_OFF_EN
                if (t || timer == TIMER_LAST) begin
                    estado_sig = APAGADO;
                end else begin
                    timer_sig = timer + 1'b1;
                end
`else
                if (t) begin
                    estado_sig = APAGADO;
                end
`endif
            end
            default: begin
                estado_sig = APAGADO;
            end
        endcase
    end

    assign foco = (estado == ENCENDIDO);

endmodule

// File: doc/apagador_escalera_temporizado.md
Name: apagador_escalera_temporizado

Overview:
- Clocked staircase-light controller: two debounced two-way lever switches (downstairs, upstairs) drive one lamp output.
- Any accepted flip of either lever toggles the lamp (two-way switch semantics).
- An optional auto-off timer turns the lamp off after a fixed on-time.
- Sits between the raw board switch inputs and the lamp driver; replaces the purely combinational two-way switch in clocked designs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a lever change is accepted (>=1).
- TIMEOUT_CYCLES, 1000: lamp on-time in clock cycles before auto-off (>=2; used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- abajo  in  1  raw downstairs lever, asynchronous to clk
- arriba  in  1  raw upstairs lever, asynchronous to clk
- foco  out  1  lamp drive, 1 = on
- evento  out  1  one-cycle pulse on each accepted lamp toggle (not on timeout)

Behaviour:
- Interface fixed: one clock (clk); rst is synchronous and active-high.
- Per input, a 2-FF synchronizer (s1 -> s2) feeds a debouncer: a counter (width $clog2(DEBOUNCE_CYCLES+1)) plus a debounced level.
  - Counter increments each cycle s2 != debounced level; it clears to 0 whenever s2 == debounced level.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, the debounced level <= s2 and the counter <= 0.
  - A change flag pulses for 1 cycle (the cycle after the level update).
- Any change of a debounced level (0->1 or 1->0) is a flip.
- Toggle request t = flip_abajo XOR flip_arriba. Simultaneous flips of both levers cancel: no toggle, no evento, timer unaffected.
- Two-state FSM: APAGADO (foco=0) and ENCENDIDO (foco=1); foco is a registered state decode.
  - APAGADO & t -> ENCENDIDO; timer <= 0; evento=1.
  - ENCENDIDO & t -> APAGADO; evento=1.
  - ENCENDIDO & timeout (feature on) -> APAGADO; evento=0.
  - Toggle and timeout in the same cycle -> APAGADO; evento=1.
- Latency: a raw edge first sampled at edge k, then held stable, changes foco at edge k+2+DEBOUNCE_CYCLES; evento is asserted in the same cycle.
- Glitch rule: a raw pulse shorter than DEBOUNCE_CYCLES cycles (after sync) produces no toggle.
- Reset:
  - s1, s2 and the debounced level load the current raw input directly, so levers held high at reset release cause no spurious toggle.
  - Debounce counters = 0, FSM = APAGADO, foco = 0, evento = 0, timer = 0.
  - Reset mid-debounce or mid-on-time aborts the operation with no pending toggle.
- Counter widths come from $clog2 of their parameter. Counters never wrap past their terminal value.

Optional Feature:
- Macro APAGADOR_AUTO_OFF_EN.
- Defined:
  - A timer (width $clog2(TIMEOUT_CYCLES)) counts each ENCENDIDO cycle.
  - When the timer == TIMEOUT_CYCLES-1, the next state is APAGADO and the timer resets to 0.
  - foco therefore stays high exactly TIMEOUT_CYCLES cycles with no intervening flip.
  - A later flip turns the lamp on again, and the timer restarts from 0.
- Undefined:
  - No timer logic; TIMEOUT_CYCLES is ignored.
  - foco changes only on toggles, and the lamp stays on indefinitely.

Test Plan:
- Reset with abajo=1, arriba=0 held; release rst; hold 20 cycles -> foco=0, evento never asserted.
- DEBOUNCE_CYCLES=4: abajo 0->1 sampled at edge k -> foco=1 and evento=1 at edge k+6; evento=0 at edge k+7.
- With the lamp on, arriba 0->1 -> foco=0 after 6 edges; then abajo 1->0 -> foco=1 (either lever toggles either way).
- 3-cycle pulse on arriba -> foco unchanged, evento stays 0. Both levers flipped on the same edge -> no toggle.
- APAGADOR_AUTO_OFF_EN, TIMEOUT_CYCLES=50: one flip -> foco high exactly 50 cycles then 0 with evento=0. Without the macro -> foco still 1 after 500 cycles.
- Assert rst at cycle 3 of a debounce window, then release -> foco=0, and no toggle follows for the aborted edge.
